// File: rtl/iob_split_tmo.sv
// IOb native-bus splitter: one registered request stage, one outstanding transaction,
// with error termination of unmapped or unresponsive accesses.
module iob_split_tmo #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                N_SLAVES    = 2,
    parameter int                P_SLAVES    = ADDR_W - 2,
    parameter int                SEL_W       = ($clog2(N_SLAVES) > 0) ? $clog2(N_SLAVES) : 1,
    parameter int                TIMEOUT_CYC = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       m_valid,
    input  logic [ADDR_W-1:0]          m_addr,
    input  logic [DATA_W-1:0]          m_wdata,
    input  logic [DATA_W/8-1:0]        m_wstrb,
    output logic [DATA_W-1:0]          m_rdata,
    output logic                       m_ready,
    output logic [N_SLAVES-1:0]        s_valid,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    output logic [DATA_W/8-1:0]        s_wstrb,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]        s_ready,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [7:0]                 err_cnt,
    input  logic                       err_clr
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = ($clog2(TIMEOUT_CYC + 1) > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int TMO_M1 = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_M1);
    localparam logic [SEL_W:0]   SEL_LIM  = (SEL_W + 1)'(N_SLAVES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]          state_r, state_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [STRB_W-1:0]   wstrb_r;
    logic [SEL_W-1:0]    sel_r, m_sel_s, nxt_sel_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [N_SLAVES-1:0] s_valid_r, onehot_s;
    logic [DATA_W-1:0]   m_rdata_r, rdata_s, rdata_sel_s;
    logic                m_ready_r, err_r, resp_s, ready_sel_s;
    logic [1:0]          code_s, err_code_r;
    logic [7:0]          err_cnt_r;

    assign m_sel_s   = m_addr[P_SLAVES -: SEL_W];
    assign nxt_sel_s = (state_r == IDLE) ? m_sel_s : sel_r;

    // Selected-slave response mux and next one-hot valid vector.
    always_comb begin
        rdata_sel_s = {DATA_W{1'b0}};
        ready_sel_s = 1'b0;
        onehot_s    = {N_SLAVES{1'b0}};
        for (int i = 0; i < N_SLAVES; i++) begin
            rdata_sel_s = rdata_sel_s | (s_rdata[i*DATA_W +: DATA_W] & {DATA_W{sel_r == SEL_W'(i)}});
            ready_sel_s = ready_sel_s | (s_ready[i] & (sel_r == SEL_W'(i)));
            onehot_s[i] = (nxt_sel_s == SEL_W'(i));
        end
    end

    // Next-state logic; resp_s marks the transition into RESP with its data and error code.
    always_comb begin
        state_s = state_r;
        resp_s  = 1'b0;
        code_s  = 2'b00;
        rdata_s = {DATA_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (m_valid) begin
                    if ({1'b0, m_sel_s} >= SEL_LIM) begin
                        state_s = RESP;
                        resp_s  = 1'b1;
                        code_s  = 2'b01;
                        rdata_s = ERR_DATA;
                    end else begin
                        state_s = REQ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                // Ready takes priority over a timeout landing in the same cycle.
                if (ready_sel_s) begin
                    state_s = RESP;
                    resp_s  = 1'b1;
                    rdata_s = (wstrb_r != {STRB_W{1'b0}}) ? {DATA_W{1'b0}} : rdata_sel_s;
                end else if ((TIMEOUT_CYC != 0) && (cnt_r == TMO_LAST)) begin
                    state_s = RESP;
                    resp_s  = 1'b1;
                    code_s  = 2'b10;
                    rdata_s = ERR_DATA;
                end else begin
                    state_s = REQ;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Transaction state, request latches and registered master/slave outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            wstrb_r   <= {STRB_W{1'b0}};
            sel_r     <= {SEL_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            s_valid_r <= {N_SLAVES{1'b0}};
            m_rdata_r <= {DATA_W{1'b0}};
            m_ready_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) && m_valid) begin
                addr_r  <= m_addr;
                wdata_r <= m_wdata;
                wstrb_r <= m_wstrb;
                sel_r   <= m_sel_s;
                cnt_r   <= {CNT_W{1'b0}};
            end else if (state_r == REQ) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            s_valid_r <= (state_s == REQ) ? onehot_s : {N_SLAVES{1'b0}};
            m_ready_r <= resp_s;
            if (resp_s) begin
                m_rdata_r <= rdata_s;
            end
            err_r <= resp_s & (code_s != 2'b00);
        end
    end

    // Error code and saturating counter; a clear during the err pulse keeps the new error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_code_r <= 2'b00;
            err_cnt_r  <= 8'd0;
        end else begin
            if (resp_s && (code_s != 2'b00)) begin
                err_code_r <= code_s;
            end else if (err_clr && !err_r) begin
                err_code_r <= 2'b00;
            end
            if (err_clr) begin
                err_cnt_r <= err_r ? 8'd1 : 8'd0;
            end else if (err_r && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end

    assign m_rdata  = m_rdata_r;
    assign m_ready  = m_ready_r;
    assign s_valid  = s_valid_r;
    assign s_addr   = addr_r;
    assign s_wdata  = wdata_r;
    assign s_wstrb  = wstrb_r;
    assign err      = err_r;
    assign err_code = err_code_r;
    assign err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_iob_split_tmo.sv
// Scenario bench for iob_split_tmo: three slaves, select field at the address MSBs, 8-cycle timeout.
module tb_iob_split_tmo;
    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m_valid;
    logic [31:0]   m_addr;
    logic [31:0]   m_wdata;
    logic [3:0]    m_wstrb;
    logic [31:0]   m_rdata;
    logic          m_ready;
    logic [NS-1:0] s_valid;
    logic [31:0]   s_addr;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;
    logic [NS*32-1:0] s_rdata;
    logic [NS-1:0] s_ready;
    logic          err;
    logic [1:0]    err_code;
    logic [7:0]    err_cnt;
    logic          err_clr;

    int n_run  = 0;
    int n_fail = 0;
    int exp_cnt = 0;
    logic [31:0] exp_rdata_q[$];
    logic        exp_err_q[$];
    logic [31:0] pop_rdata;
    logic        pop_err;

    iob_split_tmo #(
        .ADDR_W(32), .DATA_W(32), .N_SLAVES(NS), .P_SLAVES(31), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready), .s_valid(s_valid),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .s_ready(s_ready), .err(err), .err_code(err_code), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Scoreboard: every m_ready pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (rst_n && m_ready) begin
            n_run++;
            if (exp_rdata_q.size() == 0) begin
                n_fail++;
                $display("FAIL resp_unexpected: got rdata=%h err=%b, expected no response", m_rdata, err);
            end else begin
                pop_rdata = exp_rdata_q.pop_front();
                pop_err   = exp_err_q.pop_front();
                if (m_rdata !== pop_rdata || err !== pop_err) begin
                    n_fail++;
                    $display("FAIL resp_data: got rdata=%h err=%b, expected rdata=%h err=%b",
                             m_rdata, err, pop_rdata, pop_err);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input logic [31:0] rd, input logic e);
        exp_rdata_q.push_back(rd);
        exp_err_q.push_back(e);
    endtask

    task automatic set_rdata(input int idx, input logic [31:0] v);
        s_rdata[idx*32 +: 32] = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; m_valid = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_wstrb = 4'h0;
        s_rdata = {(NS*32){1'b0}}; s_ready = {NS{1'b0}}; err_clr = 1'b0;
        step(); step();
        n_run++;
        if ({s_valid, m_ready, err, err_code, err_cnt, m_rdata, s_addr, s_wdata, s_wstrb} !== 88'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: s_valid=%b m_ready=%b err=%b code=%b cnt=%0d rdata=%h, expected all zero",
                     s_valid, m_ready, err, err_code, err_cnt, m_rdata);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_read();
        m_valid = 1'b1; m_addr = 32'h4000_0010; m_wstrb = 4'h0;
        expect_resp(32'h0000_1234, 1'b0);
        step();
        n_run++;
        if (s_valid !== 3'b010 || m_ready !== 1'b0 || s_addr !== 32'h4000_0010) begin
            n_fail++;
            $display("FAIL read_req: s_valid=%b m_ready=%b s_addr=%h, expected 010 0 40000010", s_valid, m_ready, s_addr);
        end
        s_ready = 3'b010; set_rdata(1, 32'h0000_1234);
        step();
        n_run++;
        if (m_ready !== 1'b1 || s_valid !== 3'b000) begin
            n_fail++;
            $display("FAIL read_latency: m_ready=%b s_valid=%b, expected 1 000 in cycle 2", m_ready, s_valid);
        end
        m_valid = 1'b0; s_ready = 3'b000;
        step();
    endtask

    task automatic test_write();
        m_valid = 1'b1; m_addr = 32'h0000_0008; m_wdata = 32'hA5A5_A5A5; m_wstrb = 4'hF;
        set_rdata(0, 32'hFFFF_0000);
        expect_resp(32'h0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step();
            m_wdata = 32'h1111_1111 * (k + 1);
            n_run++;
            if (s_valid !== 3'b001 || s_wdata !== 32'hA5A5_A5A5 || s_wstrb !== 4'hF || m_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL write_hold k=%0d: s_valid=%b wdata=%h wstrb=%h m_ready=%b, expected 001 a5a5a5a5 f 0",
                         k, s_valid, s_wdata, s_wstrb, m_ready);
            end
            if (k == 5) s_ready = 3'b001;
        end
        step();
        s_ready = 3'b000; m_valid = 1'b0;
        n_run++;
        if (m_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL write_resp: m_ready=%b, expected 1", m_ready);
        end
        step(); step();
    endtask

    task automatic test_decode_err();
        m_valid = 1'b1; m_addr = 32'hC000_0000; m_wstrb = 4'h0;
        expect_resp(32'hDEAD_BEEF, 1'b1);
        step();
        n_run++;
        if (m_ready !== 1'b1 || s_valid !== 3'b000 || err_code !== 2'b01) begin
            n_fail++;
            $display("FAIL decode_err: m_ready=%b s_valid=%b code=%b, expected 1 000 01", m_ready, s_valid, err_code);
        end
        m_valid = 1'b0;
        step();
        exp_cnt++;
        n_run++;
        if (err_cnt !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL decode_cnt: err_cnt=%0d, expected %0d", err_cnt, exp_cnt);
        end
    endtask

    task automatic test_timeout();
        m_valid = 1'b1; m_addr = 32'h8000_0000;
        expect_resp(32'hDEAD_BEEF, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step();
            n_run++;
            if (s_valid !== 3'b100) begin
                n_fail++;
                $display("FAIL tmo_valid k=%0d: s_valid=%b, expected 100", k, s_valid);
            end
        end
        step();
        m_valid = 1'b0;
        n_run++;
        if (s_valid !== 3'b000 || m_ready !== 1'b1 || err_code !== 2'b10) begin
            n_fail++;
            $display("FAIL tmo_abort: s_valid=%b m_ready=%b code=%b, expected 000 1 10", s_valid, m_ready, err_code);
        end
        step();
        exp_cnt++;
        n_run++;
        if (err_cnt !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL tmo_cnt: err_cnt=%0d, expected %0d", err_cnt, exp_cnt);
        end
        m_valid = 1'b1; m_addr = 32'h8000_0004; set_rdata(2, 32'hCAFE_0002);
        expect_resp(32'hCAFE_0002, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 7) s_ready = 3'b100;
        end
        step();
        s_ready = 3'b000; m_valid = 1'b0;
        n_run++;
        if (m_ready !== 1'b1 || err_code !== 2'b10 || err_cnt !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL tmo_edge_ready: m_ready=%b code=%b cnt=%0d, expected 1 10 %0d", m_ready, err_code, err_cnt, exp_cnt);
        end
        step();
    endtask

    task automatic test_ignore_and_saturate();
        s_ready = 3'b111;
        step(); step();
        n_run++;
        if (s_valid !== 3'b000 || m_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_ready_idle: s_valid=%b m_ready=%b, expected 000 0", s_valid, m_ready);
        end
        s_ready = 3'b001; m_valid = 1'b1; m_addr = 32'h4000_0000; set_rdata(1, 32'h0000_0055);
        for (int k = 0; k < 3; k++) begin
            step();
            n_run++;
            if (s_valid !== 3'b010 || m_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL wrong_port_ready k=%0d: s_valid=%b m_ready=%b, expected 010 0", k, s_valid, m_ready);
            end
        end
        s_ready = 3'b010;
        expect_resp(32'h0000_0055, 1'b0);
        step();
        s_ready = 3'b000; m_valid = 1'b0;
        step();
        // Back-to-back decode errors with m_valid held high.
        m_valid = 1'b1; m_addr = 32'hC000_0000;
        for (int k = 0; k < 300; k++) begin
            expect_resp(32'hDEAD_BEEF, 1'b1);
            step(); step();
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
        end
        m_valid = 1'b0;
        step();
        n_run++;
        if (err_cnt !== 8'(exp_cnt) || exp_rdata_q.size() != 0) begin
            n_fail++;
            $display("FAIL err_saturate: err_cnt=%0d pending=%0d, expected %0d 0", err_cnt, exp_rdata_q.size(), exp_cnt);
        end
        m_valid = 1'b1;
        expect_resp(32'hDEAD_BEEF, 1'b1);
        step();
        m_valid = 1'b0; err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_run++;
        if (err_cnt !== 8'd1 || err_code !== 2'b01) begin
            n_fail++;
            $display("FAIL clr_coincide: err_cnt=%0d code=%b, expected 1 01", err_cnt, err_code);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        exp_cnt = 0;
        n_run++;
        if (err_cnt !== 8'd0 || err_code !== 2'b00) begin
            n_fail++;
            $display("FAIL err_clear: err_cnt=%0d code=%b, expected 0 00", err_cnt, err_code);
        end
    endtask

    task automatic test_async_reset();
        m_valid = 1'b1; m_addr = 32'h4000_0000;
        step();
        n_run++;
        if (s_valid !== 3'b010) begin
            n_fail++;
            $display("FAIL rst_pre: s_valid=%b, expected 010", s_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_run++;
        if (s_valid !== 3'b000 || m_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: s_valid=%b m_ready=%b, expected 000 0 before the next edge", s_valid, m_ready);
        end
        m_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        m_valid = 1'b1; m_addr = 32'h0000_0004; m_wstrb = 4'h0; set_rdata(0, 32'h0000_0077);
        expect_resp(32'h0000_0077, 1'b0);
        step();
        s_ready = 3'b001;
        step();
        s_ready = 3'b000; m_valid = 1'b0;
        n_run++;
        if (m_ready !== 1'b1 || err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_recover: m_ready=%b err_cnt=%0d, expected 1 0", m_ready, err_cnt);
        end
        step(); step();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_decode_err();
        test_timeout();
        test_ignore_and_saturate();
        test_async_reset();
        n_run++;
        if (exp_rdata_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_resp: %0d responses outstanding, expected 0", exp_rdata_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
